// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: opcodes, FSM state type, and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SRL  = 4'h3;
    localparam logic [3:0] OP_SRA  = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_XNOR = 4'hB;

    typedef enum logic {StIdle, StMul} state_t;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic [3:0] mk_flags(input logic z, input logic n, input logic c,
                                            input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
// done is asserted during the final iteration cycle; prod_lo/prod_hi_nz are valid alongside it.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Final-step accumulator is exposed so the product is usable on the same edge it completes.
    assign done       = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_lo    = acc_d[WIDTH-1:0];
    assign prod_hi_nz = |acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mplier_q <= b;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with registered result/flags and valid/ready handshakes on both sides.
// Define ALU_PIPE_MUL_EN to add the iterative MUL opcode; otherwise opcode 5 reports illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             illegal_q;

    logic             accept;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic [3:0]       alu_flags;

    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

`ifdef ALU_PIPE_MUL_EN
    assign is_mul = (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_mul),
        .a         (a),
        .b         (b),
        .done      (mul_done),
        .prod_lo   (mul_lo),
        .prod_hi_nz(mul_hi_nz)
    );
`else
    assign is_mul    = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
`endif

    assign sh = b[SHW-1:0];

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        // MSB of the extended difference is the unsigned borrow.
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_XNOR: alu_res = ~(a ^ b);
            default: alu_ill = 1'b1;
        endcase
        alu_flags = mk_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (accept && is_mul) begin
                        state_q <= StMul;
                    end else if (accept) begin
                        result_q    <= alu_res;
                        flags_q     <= alu_flags;
                        illegal_q   <= alu_ill;
                        out_valid_q <= 1'b1;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        result_q    <= mul_lo;
                        flags_q     <= mk_flags(mul_lo == '0, mul_lo[WIDTH-1], mul_hi_nz, 1'b0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed corner cases plus random ops with backpressure.
module tb_alu_pipe;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         illegal;

    int   total = 0;
    int   bad = 0;
    bit   rdy_mode = 1'b0;
    exp_t sb[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model from arithmetic definitions; flags packed as {Z,N,C,V}.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned wide;
        longint          sres;
        int              n = int'(y[4:0]);
        logic [W-1:0]    r = '0;
        logic            c = 1'b0;
        logic            v = 1'b0;
        logic            ill = 1'b0;
        exp_t            e;
        case (o)
            4'h0: begin
                wide = ux + uy;
                r    = wide[31:0];
                c    = wide[32];
                sres = sx + sy;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'h1: begin
                r    = x - y;
                c    = (ux < uy);
                sres = sx - sy;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'h2: r = x << n;
            4'h3: r = x >> n;
            4'h4: r = $signed(x) >>> n;
`ifdef ALU_PIPE_MUL_EN
            4'h5: begin
                wide = ux * uy;
                r    = wide[31:0];
                c    = (wide[63:32] != 0);
            end
`endif
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hA: r = x ^ y;
            4'hB: r = ~(x ^ y);
            default: ill = 1'b1;
        endcase
        e.res = r;
        e.fl  = {(r == 0), r[W-1], c, v};
        e.ill = ill;
        return e;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", 64'(guard), 0);
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int busy);
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic run_dir(input string name, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] wres,
                           input logic [3:0] wfl, input logic will, input int wlat,
                           input int wbusy);
        int lat;
        int busy;
        repeat (2) @(negedge clk);
        issue(o, x, y);
        wait_out(lat, busy);
        chk({name, "_latency"}, 64'(lat), 64'(wlat));
        chk({name, "_busy_cycles"}, 64'(busy), 64'(wbusy));
        chk({name, "_result"}, 64'(result), 64'(wres));
        chk({name, "_flags"}, 64'(flags), 64'(wfl));
        chk({name, "_illegal"}, 64'(illegal), 64'(will));
    endtask

    task automatic stream_test();
        int n;
        logic [W-1:0] want [4];
        want = '{32'h88888888, 32'hFFFFFFFF, 32'h77777777, 32'h88888888};
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                issue(4'h8, 32'hAAAAAAAA, 32'hDDDDDDDD);
                issue(4'h9, 32'hAAAAAAAA, 32'hDDDDDDDD);
                issue(4'hA, 32'hAAAAAAAA, 32'hDDDDDDDD);
                issue(4'hB, 32'hAAAAAAAA, 32'hDDDDDDDD);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 20);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_valid", 64'(out_valid), 1);
                    chk("bp_result", 64'(result), 64'h88888888);
                    chk("bp_in_ready", 64'(in_ready), 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stream_valid", 64'(out_valid), 1);
                    chk("stream_result", 64'(result), 64'(want[i]));
                end
            end
        join
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected items on each handshake and checks stability under backpressure.
    logic         pend = 1'b0;
    logic [W-1:0] p_res;
    logic [3:0]   p_fl;
    logic         p_ill;
    exp_t         e_mon;

    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_result", 64'(result), 64'(p_res));
                chk("hold_flags", 64'(flags), 64'(p_fl));
                chk("hold_illegal", 64'(illegal), 64'(p_ill));
            end
            pend = 1'b0;
            if (!rst && out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'(out_valid), 0);
                    end else begin
                        e_mon = sb.pop_front();
                        chk("sb_result", 64'(result), 64'(e_mon.res));
                        chk("sb_flags", 64'(flags), 64'(e_mon.fl));
                        chk("sb_illegal", 64'(illegal), 64'(e_mon.ill));
                    end
                end else begin
                    pend  = 1'b1;
                    p_res = result;
                    p_fl  = flags;
                    p_ill = illegal;
                end
            end
        end
    end

    initial begin
        #1000000;
        chk("watchdog", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int cnt;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_flags", 64'(flags), 0);
        chk("rst_illegal", 64'(illegal), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 1);

        run_dir("add_ovf", 4'h0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 4'b0101, 1'b0, 1, 0);
        run_dir("sub_borrow", 4'h1, 32'h00000002, 32'h0000000A, 32'hFFFFFFF8, 4'b0110, 1'b0, 1, 0);
        run_dir("sub_zero", 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b1000, 1'b0, 1, 0);
        run_dir("sra", 4'h4, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0100, 1'b0, 1, 0);
        run_dir("op_e", 4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h0, 4'b1000, 1'b1, 1, 0);
`ifdef ALU_PIPE_MUL_EN
        run_dir("mul", 4'h5, 32'h00010000, 32'h00010000, 32'h0, 4'b1010, 1'b0, 33, 32);
`else
        run_dir("mul_off", 4'h5, 32'h00010000, 32'h00010000, 32'h0, 4'b1000, 1'b1, 1, 0);
`endif
        stream_test();

        // Reset in the middle of a multiply, with a request pending during the reset cycle.
        repeat (2) @(negedge clk);
        issue(4'h5, 32'h00000003, 32'h00000005);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        op = 4'h0;
        a = 32'h1;
        b = 32'h1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 0);
        chk("midrst_in_ready", 64'(in_ready), 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_output", 64'(cnt), 0);

        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
